// File: rtl/iterative_alu.sv
// iterative_alu: registered execute-stage ALU with compare, barrel shifts and a start/done handshake.
// Define ALU_MULDIV_EN to build the iterative shift-add multiplier and restoring divider (opcodes 10-15).
module iterative_alu #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_BITS = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       operation,
    input  logic [WIDTH-1:0] leftOperand,
    input  logic [WIDTH-1:0] rightOperand,
    input  logic             signedComparison,
    input  logic [2:0]       comparisonOperation,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             comparisonResult,
    output logic             divideByZero,
    output logic             illegalOperation
);

    typedef enum logic [1:0] {ST_IDLE, ST_MULTIPLY, ST_DIVIDE} state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_HIGH = 4'd2;
    localparam logic [3:0] OP_XOR  = 4'd3;
    localparam logic [3:0] OP_XNOR = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_SHR  = 4'd8;
    localparam logic [3:0] OP_SAR  = 4'd9;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cmp_q, cmp_d;
    logic             dbz_q, dbz_d;
    logic             illegal_q, illegal_d;
    logic             done_q, done_d;

    logic                  accept;
    logic [SHIFT_BITS-1:0] shamt;
    logic [WIDTH-1:0]      single_result;
    logic                  cmp_eq, cmp_lt, cmp_value;

`ifdef ALU_MULDIV_EN
    localparam logic [3:0] OP_MULU = 4'd11;

    logic [SHIFT_BITS-1:0] count_q, count_d;
    logic [WIDTH-1:0]      a_q, a_d;
    logic [WIDTH-1:0]      b_q, b_d;
    logic [WIDTH-1:0]      acc_q, acc_d;
    logic                  quot_neg_q, quot_neg_d;
    logic                  rem_neg_q, rem_neg_d;
    logic                  want_rem_q, want_rem_d;

    logic             signed_div, left_neg, right_neg;
    logic [WIDTH-1:0] left_mag, right_mag;
    logic [WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]   div_shifted, div_trial;
    logic             div_fits;
    logic [WIDTH-1:0] rem_next, quot_next, div_final;
`endif

    assign accept = start & (state_q == ST_IDLE);

    always_comb begin
        shamt = rightOperand[SHIFT_BITS-1:0];
        single_result = '0;
        case (operation)
            OP_ADD:  single_result = leftOperand + rightOperand;
            OP_SUB:  single_result = leftOperand - rightOperand;
            OP_HIGH: single_result = {rightOperand[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_XOR:  single_result = leftOperand ^ rightOperand;
            OP_XNOR: single_result = ~(leftOperand ^ rightOperand);
            OP_AND:  single_result = leftOperand & rightOperand;
            OP_OR:   single_result = leftOperand | rightOperand;
            OP_SHL:  single_result = leftOperand << shamt;
            OP_SHR:  single_result = leftOperand >> shamt;
            OP_SAR:  single_result = $unsigned($signed(leftOperand) >>> shamt);
            default: single_result = '0;
        endcase
    end

    always_comb begin
        cmp_eq = (leftOperand == rightOperand);
        // Sign of the (WIDTH+1)-bit extended difference, expressed as a compare of the extended operands.
        cmp_lt = $signed({signedComparison & leftOperand[WIDTH-1], leftOperand})
               < $signed({signedComparison & rightOperand[WIDTH-1], rightOperand});
        case (comparisonOperation)
            3'd0:    cmp_value = cmp_eq;
            3'd1:    cmp_value = ~cmp_eq;
            3'd2:    cmp_value = cmp_lt;
            3'd3:    cmp_value = cmp_eq | cmp_lt;
            3'd4:    cmp_value = ~cmp_eq & ~cmp_lt;
            3'd5:    cmp_value = ~cmp_lt;
            default: cmp_value = 1'b0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    always_comb begin
        signed_div = ~operation[0];
        left_neg   = signed_div & leftOperand[WIDTH-1];
        right_neg  = signed_div & rightOperand[WIDTH-1];
        left_mag   = left_neg  ? -leftOperand  : leftOperand;
        right_mag  = right_neg ? -rightOperand : rightOperand;

        mul_acc_next = acc_q + (b_q[0] ? a_q : '0);

        // One restoring step: acc_q holds the partial remainder, a_q shifts dividend bits out and quotient bits in.
        div_shifted = {acc_q, a_q[WIDTH-1]};
        div_trial   = div_shifted - {1'b0, b_q};
        div_fits    = ~div_trial[WIDTH];
        rem_next    = div_fits ? div_trial[WIDTH-1:0] : div_shifted[WIDTH-1:0];
        quot_next   = {a_q[WIDTH-2:0], div_fits};

        if (want_rem_q) begin
            div_final = rem_neg_q ? -rem_next : rem_next;
        end else begin
            div_final = quot_neg_q ? -quot_next : quot_next;
        end
    end
`endif

    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        cmp_d     = cmp_q;
        dbz_d     = dbz_q;
        illegal_d = illegal_q;
        done_d    = 1'b0;
`ifdef ALU_MULDIV_EN
        count_d    = count_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        quot_neg_d = quot_neg_q;
        rem_neg_d  = rem_neg_q;
        want_rem_d = want_rem_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cmp_d     = cmp_value;
                    dbz_d     = 1'b0;
                    illegal_d = 1'b0;
                    if (operation <= OP_SAR) begin
                        result_d = single_result;
                        done_d   = 1'b1;
                    end else begin
`ifdef ALU_MULDIV_EN
                        if (operation <= OP_MULU) begin
                            state_d = ST_MULTIPLY;
                            count_d = SHIFT_BITS'(WIDTH - 1);
                            a_d     = leftOperand;
                            b_d     = rightOperand;
                            acc_d   = '0;
                        end else if (rightOperand == '0) begin
                            result_d = operation[1] ? leftOperand : '1;
                            dbz_d    = 1'b1;
                            done_d   = 1'b1;
                        end else begin
                            state_d    = ST_DIVIDE;
                            count_d    = SHIFT_BITS'(WIDTH - 1);
                            a_d        = left_mag;
                            b_d        = right_mag;
                            acc_d      = '0;
                            quot_neg_d = left_neg ^ right_neg;
                            rem_neg_d  = left_neg;
                            want_rem_d = operation[1];
                        end
`else
                        result_d  = '0;
                        illegal_d = 1'b1;
                        done_d    = 1'b1;
`endif
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            ST_MULTIPLY: begin
                acc_d = mul_acc_next;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                if (count_q == '0) begin
                    state_d  = ST_IDLE;
                    result_d = mul_acc_next;
                    done_d   = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            ST_DIVIDE: begin
                acc_d = rem_next;
                a_d   = quot_next;
                if (count_q == '0) begin
                    state_d  = ST_IDLE;
                    result_d = div_final;
                    done_d   = 1'b1;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the pre-edge value of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            cmp_q     <= 1'b0;
            dbz_q     <= 1'b0;
            illegal_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef ALU_MULDIV_EN
            count_q    <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            quot_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            want_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            cmp_q     <= cmp_d;
            dbz_q     <= dbz_d;
            illegal_q <= illegal_d;
            done_q    <= done_d;
`ifdef ALU_MULDIV_EN
            count_q    <= count_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            quot_neg_q <= quot_neg_d;
            rem_neg_q  <= rem_neg_d;
            want_rem_q <= want_rem_d;
`endif
        end
    end

    assign ready            = (state_q == ST_IDLE);
    assign done             = done_q;
    assign result           = result_q;
    assign comparisonResult = cmp_q;
    assign divideByZero     = dbz_q;
    assign illegalOperation = illegal_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Scoreboard bench for iterative_alu (WIDTH=32): driver pushes model predictions, a negedge monitor pops on done.
// Expectations follow ALU_MULDIV_EN the same way the design does.
module tb_iterative_alu;

    localparam int W = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   operation = '0;
    logic [W-1:0] leftOperand = '0;
    logic [W-1:0] rightOperand = '0;
    logic         signedComparison = 1'b0;
    logic [2:0]   comparisonOperation = '0;
    logic         ready, done, comparisonResult, divideByZero, illegalOperation;
    logic [W-1:0] result;

    typedef struct {
        logic [W-1:0] res;
        logic         cmp;
        logic         dbz;
        logic         ill;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    iterative_alu #(.WIDTH(W), .SHIFT_BITS(5)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .operation           (operation),
        .leftOperand         (leftOperand),
        .rightOperand        (rightOperand),
        .signedComparison    (signedComparison),
        .comparisonOperation (comparisonOperation),
        .ready               (ready),
        .done                (done),
        .result              (result),
        .comparisonResult    (comparisonResult),
        .divideByZero        (divideByZero),
        .illegalOperation    (illegalOperation)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference behaviour from the opcode table, using 64-bit arithmetic and truncation.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] l, input logic [W-1:0] r,
                                   input logic sgn, input logic [2:0] cop);
        exp_t   e;
        longint sl, sr;
        logic   lt, eq;
        int     amt;
        sl = longint'($signed(l));
        sr = longint'($signed(r));
        amt = int'(r % 32);
        eq = (l == r);
        lt = sgn ? (sl < sr) : (l < r);
        e.res = '0; e.dbz = 1'b0; e.ill = 1'b0; e.due = 0;
        case (cop)
            3'd0: e.cmp = eq;
            3'd1: e.cmp = !eq;
            3'd2: e.cmp = lt;
            3'd3: e.cmp = lt || eq;
            3'd4: e.cmp = !lt && !eq;
            3'd5: e.cmp = !lt;
            default: e.cmp = 1'b0;
        endcase
        case (op)
            4'd0: e.res = W'(sl + sr);
            4'd1: e.res = W'(sl - sr);
            4'd2: e.res = W'(longint'(r % 65536) * 65536);
            4'd3: e.res = l ^ r;
            4'd4: e.res = ~(l ^ r);
            4'd5: e.res = l & r;
            4'd6: e.res = l | r;
            4'd7: e.res = W'(longint'(l) * (longint'(1) << amt));
            4'd8: e.res = W'(longint'(l) / (longint'(1) << amt));
            4'd9: e.res = W'(sl >>> amt);
            default: begin
`ifdef ALU_MULDIV_EN
                e.due = W;
                case (op)
                    4'd10, 4'd11: e.res = W'(longint'(l) * longint'(r));
                    4'd12: e.res = (r == 0) ? '1 : W'(sl / sr);
                    4'd13: e.res = (r == 0) ? '1 : l / r;
                    4'd14: e.res = (r == 0) ? l  : W'(sl % sr);
                    default: e.res = (r == 0) ? l : l % r;
                endcase
                if (op >= 4'd12 && r == 0) begin
                    e.dbz = 1'b1;
                    e.due = 0;
                end
`else
                e.ill = 1'b1;
`endif
            end
        endcase
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the accept edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] l, input logic [W-1:0] r,
                         input logic sgn, input logic [2:0] cop, input bit expect_done);
        exp_t e;
        int   n;
        n = 0;
        while (!ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 200 cycles");
            return;
        end
        operation = op; leftOperand = l; rightOperand = r;
        signedComparison = sgn; comparisonOperation = cop; start = 1'b1;
        e = model(op, l, r, sgn, cop);
        e.due = e.due + cyc + 1;
        if (expect_done) sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        leftOperand = $urandom;
        rightOperand = $urandom;
        operation = 4'($urandom_range(0, 15));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("latency", W'(cyc), W'(e.due));
                    check("result", result, e.res);
                    check("comparisonResult", W'(comparisonResult), W'(e.cmp));
                    check("divideByZero", W'(divideByZero), W'(e.dbz));
                    check("illegalOperation", W'(illegalOperation), W'(e.ill));
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_done: got no done expected done at cycle %0d (now %0d)", e.due, cyc);
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_ready"}, W'(ready), W'(1));
        check({tag, "_done"}, W'(done), W'(0));
        check({tag, "_result"}, result, '0);
        check({tag, "_cmp"}, W'(comparisonResult), W'(0));
        check({tag, "_dbz"}, W'(divideByZero), W'(0));
        check({tag, "_ill"}, W'(illegalOperation), W'(0));
    endtask

    initial begin
        logic [3:0]   rop;
        logic [W-1:0] rl, rr;
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_reset_values("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Compare and single-cycle ops, issued back to back.
        issue(4'd1, 32'd3, 32'd5, 1'b1, 3'd2, 1'b1);
        issue(4'd1, 32'd3, 32'd5, 1'b0, 3'd5, 1'b1);
        issue(4'd0, 32'd7, 32'd7, 1'b0, 3'd0, 1'b1);
        issue(4'd9, 32'h8000_0000, 32'd33, 1'b1, 3'd4, 1'b1);
        issue(4'd8, 32'h8000_0000, 32'd33, 1'b0, 3'd4, 1'b1);
        issue(4'd2, 32'h0, 32'h1234_ABCD, 1'b0, 3'd6, 1'b1);
        issue(4'd7, 32'h0000_0001, 32'd31, 1'b1, 3'd3, 1'b1);

        // Multiply with ignored start pulses while busy.
        issue(4'd10, 32'hFFFF_FFFF, 32'd3, 1'b1, 3'd1, 1'b1);
`ifdef ALU_MULDIV_EN
        repeat (4) @(posedge clk);
        #1 check("busy_ready", W'(ready), W'(0));
        operation = 4'd12; leftOperand = 32'd100; rightOperand = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
`endif

        issue(4'd12, 32'hFFFF_FFF9, 32'd2, 1'b1, 3'd2, 1'b1);
        issue(4'd14, 32'hFFFF_FFF9, 32'd2, 1'b1, 3'd2, 1'b1);
        issue(4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 3'd0, 1'b1);
        issue(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 3'd0, 1'b1);
        issue(4'd13, 32'd9, 32'd0, 1'b0, 3'd4, 1'b1);
        issue(4'd15, 32'd9, 32'd0, 1'b0, 3'd4, 1'b1);
        issue(4'd11, 32'd2, 32'd3, 1'b0, 3'd2, 1'b1);
        issue(4'd15, 32'hFFFF_FFFF, 32'h0000_0010, 1'b1, 3'd7, 1'b1);

        // Randomized mix, including zero divisors and small operands.
        for (int i = 0; i < 80; i++) begin
            rop = 4'($urandom_range(0, 15));
            rl = $urandom;
            rr = $urandom;
            if ($urandom_range(0, 7) == 0) rr = '0;
            if ($urandom_range(0, 3) == 0) begin
                rl = W'($urandom_range(0, 40)) - 32'd20;
                rr = W'($urandom_range(0, 40)) - 32'd20;
            end
            issue(rop, rl, rr, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b1);
        end

        // Reset in the middle of a divide aborts it without a done.
        issue(4'd0, 32'd1, 32'd1, 1'b0, 3'd0, 1'b1);
        issue(4'd13, 32'd100, 32'd7, 1'b0, 3'd0, !MULDIV);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        #1 check_reset_values("midop_reset");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        issue(4'd0, 32'd5, 32'd3, 1'b0, 3'd0, 1'b1);

        for (int n = 0; n < 200 && sb.size() > 0; n++) begin
            @(posedge clk); #1;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
